ldpc_dvb_dec_cnode_sort: RTL and testbench
==========================================

# ldpc_dvb_dec_cnode_sort

Check-node min-sum compressor for the DVB-S2 LDPC decoder horizontal step. It consumes the stream of signed variable-node messages belonging to one check-node row and reduces them to the packed record: min1, min2, min1 column index and product sign. `ldpc_dvb_dec_cnode_restore` later expands that record back into per-edge check-node messages. It also forwards each edge's sign and index for the sign/index store.

## Interface
Parameters:
- pNODE_W, 8, width of signed vnode message and of min1/min2 magnitude fields
- pIDX_W, 5, width of column index within a row
- pCTX_W, 16, width of opaque cnode context carried from row start to result

Ports:
- iclk  in  1  clock; all state updates on rising edge
- ireset  in  1  reset; synchronous, active-low (0 = reset)
- iclkena  in  1  clock enable; when 0 every register holds
- istart  in  1  decode start; synchronous flush of row state and valid pipeline
- ival  in  1  input edge valid; qualifies all strobes and data below
- isop  in  1  first edge of row
- ieop  in  1  last edge of row
- ivnode  in  pNODE_W  signed two's-complement vnode message
- ivnode_idx  in  pIDX_W  column index of the edge
- ivnode_mask  in  1  1 = edge excluded from min/sign search
- icnode_ctx  in  pCTX_W  row context, sampled with isop
- osign_val  out  1  per-edge sign output valid
- osign  out  1  sign of ivnode (0 for masked edges)
- osign_idx  out  pIDX_W  edge index echoed
- ovn_min_val  out  1  packed row result valid, one-cycle pulse
- omin1  out  pNODE_W  smallest magnitude
- omin2  out  pNODE_W  second-smallest magnitude
- omin1_col  out  pIDX_W  index of min1 edge
- oprod_sign  out  1  XOR of signs of unmasked edges
- octx  out  pCTX_W  context captured at isop of this row

## Operation
- Stage 1 (registered): abs = |ivnode|, saturated. -2^(pNODE_W-1) maps to MAX = 2^(pNODE_W-1)-1. sign = ivnode MSB. Mask, idx, sop and eop are piped alongside.
- Stage 1 also drives osign_val/osign/osign_idx for every accepted edge, including masked ones.
- Stage 2 accumulator, with state flag row_open:
  - isop edge: row_open=1, ctx captured.
    - Unmasked: min1=abs, min2=MAX, col=idx, psign=sign.
    - Masked: min1=min2=MAX, col=0, psign=0.
  - Non-sop unmasked edge with row_open:
    - If abs < min1: min2=min1, min1=abs, col=idx.
    - Else if abs < min2: min2=abs.
    - psign ^= sign.
  - Masked non-sop edge: no update.
- Strict compares only:
  - On equal magnitudes, min1_col keeps the earliest edge.
  - An equal value goes to min2.
- ieop edge (after its own update, sop+eop allowed): register outputs from the updated values, pulse ovn_min_val, row_open=0.
- Edge with ival=1, isop=0 while row_open=0: dropped from accumulation (still emitted on osign). If it carries ieop, no result is produced.
- isop while row_open=1: the open row is discarded silently and the new row starts.
- istart: row_open=0, stage-1/stage-2 valids cleared in the same cycle. istart dominates a simultaneous ival.
- Result fields hold their last value between pulses.

## Timing
- Reset (ireset=0 at clock edge, iclkena ignored):
  - osign_val=0, ovn_min_val=0.
  - osign=0, osign_idx=0, omin1=0, omin2=0, omin1_col=0, oprod_sign=0, octx=0.
  - row_open=0.
- Latency:
  - Edge at cycle t gives osign at t+1.
  - ieop at cycle t gives ovn_min_val at t+2.
- Throughput: one edge per cycle, back-to-back rows with zero gap (isop the cycle after ieop) supported.
- iclkena=0 freezes the pipeline; a pulse stays asserted until the next enabled edge.
- Reset asserted mid-row discards the row; no result pulse follows.

## Test plan
- Row ivnode +5,-3,+7,-3 at idx 0..3, ctx=0x00A5, pNODE_W=8 -> ovn_min_val at eop+2, with min1=3, min2=3, min1_col=1, prod_sign=0, octx=0x00A5.
- Single-edge row (isop=ieop=1), ivnode=-128, idx 4 -> min1=127, min2=127, min1_col=4, prod_sign=1.
- Row -2(masked), +9, -6 -> min1=6, min2=9, min1_col=2, prod_sign=1; osign sequence 0,0,1.
- Two back-to-back rows {4,1,8} then {-7,-7} -> results on consecutive cycles:
  - Row 1: 1/4/col1/0.
  - Row 2: 7/7/col0/0.
- istart asserted after 2 edges of an open row, then ieop edge -> no ovn_min_val. A following full row {3,-1} yields 1/3/col1/1.
- ireset=0 for one cycle mid-row with iclkena=0 -> all outputs zero next cycle and no stale result.

Source files
------------

// File: rtl/ldpc_dvb_dec_cnode_sort_if.sv
// Edge-stream and packed-result bundle for the check-node min-sum compressor.
// The slave side is the compressor; the master side feeds edges and reads results.
interface ldpc_dvb_dec_cnode_sort_if #(
  parameter int pNODE_W = 8,
  parameter int pIDX_W  = 5,
  parameter int pCTX_W  = 16
);
  logic                      iclkena;
  logic                      istart;
  logic                      ival;
  logic                      isop;
  logic                      ieop;
  logic signed [pNODE_W-1:0] ivnode;
  logic        [pIDX_W-1:0]  ivnode_idx;
  logic                      ivnode_mask;
  logic        [pCTX_W-1:0]  icnode_ctx;

  logic                      osign_val;
  logic                      osign;
  logic        [pIDX_W-1:0]  osign_idx;
  logic                      ovn_min_val;
  logic        [pNODE_W-1:0] omin1;
  logic        [pNODE_W-1:0] omin2;
  logic        [pIDX_W-1:0]  omin1_col;
  logic                      oprod_sign;
  logic        [pCTX_W-1:0]  octx;

  modport master (
    output iclkena, istart, ival, isop, ieop, ivnode, ivnode_idx, ivnode_mask, icnode_ctx,
    input  osign_val, osign, osign_idx, ovn_min_val, omin1, omin2, omin1_col, oprod_sign, octx
  );

  modport slave (
    input  iclkena, istart, ival, isop, ieop, ivnode, ivnode_idx, ivnode_mask, icnode_ctx,
    output osign_val, osign, osign_idx, ovn_min_val, omin1, omin2, omin1_col, oprod_sign, octx
  );
endinterface

// File: rtl/ldpc_dvb_dec_cnode_sort.sv
// Check-node min-sum compressor: reduces one row of signed vnode messages to
// {min1, min2, min1 column, product sign, context} and echoes per-edge signs.
module ldpc_dvb_dec_cnode_sort #(
  parameter int pNODE_W = 8,
  parameter int pIDX_W  = 5,
  parameter int pCTX_W  = 16
) (
  input  logic                   iclk,
  input  logic                   ireset,
  ldpc_dvb_dec_cnode_sort_if.slave bus
);

  localparam logic [pNODE_W-1:0] MAX = {1'b0, {(pNODE_W-1){1'b1}}};

  // |v| with the most negative code clipped to MAX instead of wrapping
  function automatic logic [pNODE_W-1:0] sat_abs(input logic signed [pNODE_W-1:0] v);
    logic [pNODE_W-1:0] neg;
    neg = -v;
    if (!v[pNODE_W-1])        sat_abs = v;
    else if (neg[pNODE_W-1])  sat_abs = MAX;
    else                      sat_abs = neg;
  endfunction

  logic                 r_vld_p1, r_sop_p1, r_eop_p1, r_mask_p1, r_sign_p1;
  logic [pIDX_W-1:0]    r_idx_p1;
  logic [pNODE_W-1:0]   r_abs_p1;
  logic [pCTX_W-1:0]    r_ctx_p1;

  logic                 r_row_open;
  logic [pNODE_W-1:0]   r_min1, r_min2;
  logic [pIDX_W-1:0]    r_col;
  logic                 r_psign;
  logic [pCTX_W-1:0]    r_ctx;

  logic                 r_vld_p2;
  logic [pNODE_W-1:0]   r_min1_p2, r_min2_p2;
  logic [pIDX_W-1:0]    r_col_p2;
  logic                 r_psign_p2;
  logic [pCTX_W-1:0]    r_ctx_p2;

  logic                 w_sop, w_acc;
  logic [pNODE_W-1:0]   w_min1, w_min2;
  logic [pIDX_W-1:0]    w_col;
  logic                 w_psign;
  logic [pCTX_W-1:0]    w_ctx;

  // Stage 1: magnitude/sign split; also the per-edge sign output
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      r_vld_p1  <= 1'b0;
      r_sign_p1 <= 1'b0;
      r_idx_p1  <= '0;
    end else if (bus.iclkena) begin
      r_vld_p1 <= bus.ival & ~bus.istart;
      if (bus.ival) begin
        r_sign_p1 <= bus.ivnode[pNODE_W-1] & ~bus.ivnode_mask;
        r_idx_p1  <= bus.ivnode_idx;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (bus.iclkena && bus.ival) begin
      r_abs_p1  <= sat_abs(bus.ivnode);
      r_mask_p1 <= bus.ivnode_mask;
      r_sop_p1  <= bus.isop;
      r_eop_p1  <= bus.ieop;
      r_ctx_p1  <= bus.icnode_ctx;
    end
  end

  // Stage 2: running two-minimum search; strict compares keep the earliest min1
  always_comb begin
    w_min1  = r_min1;
    w_min2  = r_min2;
    w_col   = r_col;
    w_psign = r_psign;
    w_ctx   = r_ctx;
    w_sop   = r_vld_p1 & r_sop_p1;
    w_acc   = r_vld_p1 & (r_sop_p1 | r_row_open);
    if (w_sop) begin
      w_ctx = r_ctx_p1;
      if (r_mask_p1) begin
        w_min1  = MAX;
        w_min2  = MAX;
        w_col   = '0;
        w_psign = 1'b0;
      end else begin
        w_min1  = r_abs_p1;
        w_min2  = MAX;
        w_col   = r_idx_p1;
        w_psign = r_sign_p1;
      end
    end else if (w_acc && !r_mask_p1) begin
      if (r_abs_p1 < r_min1) begin
        w_min2 = r_min1;
        w_min1 = r_abs_p1;
        w_col  = r_idx_p1;
      end else if (r_abs_p1 < r_min2) begin
        w_min2 = r_abs_p1;
      end
      w_psign = r_psign ^ r_sign_p1;
    end
  end

  always_ff @(posedge iclk) begin
    if (bus.iclkena && !bus.istart && w_acc) begin
      r_min1  <= w_min1;
      r_min2  <= w_min2;
      r_col   <= w_col;
      r_psign <= w_psign;
      r_ctx   <= w_ctx;
    end
  end

  // Stage 2 output: the packed record is latched only on a closing edge
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      r_row_open <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_min1_p2  <= '0;
      r_min2_p2  <= '0;
      r_col_p2   <= '0;
      r_psign_p2 <= 1'b0;
      r_ctx_p2   <= '0;
    end else if (bus.iclkena) begin
      if (bus.istart) begin
        r_row_open <= 1'b0;
        r_vld_p2   <= 1'b0;
      end else begin
        r_vld_p2 <= w_acc & r_eop_p1;
        if (w_acc) r_row_open <= ~r_eop_p1;
        if (w_acc && r_eop_p1) begin
          r_min1_p2  <= w_min1;
          r_min2_p2  <= w_min2;
          r_col_p2   <= w_col;
          r_psign_p2 <= w_psign;
          r_ctx_p2   <= w_ctx;
        end
      end
    end
  end

  assign bus.osign_val   = r_vld_p1;
  assign bus.osign       = r_sign_p1;
  assign bus.osign_idx   = r_idx_p1;
  assign bus.ovn_min_val = r_vld_p2;
  assign bus.omin1       = r_min1_p2;
  assign bus.omin2       = r_min2_p2;
  assign bus.omin1_col   = r_col_p2;
  assign bus.oprod_sign  = r_psign_p2;
  assign bus.octx        = r_ctx_p2;

endmodule

// File: tb/tb_ldpc_dvb_dec_cnode_sort.sv
// Bench for the check-node min-sum compressor: directed rows with literal
// expectations plus randomized rows checked against a sorting reference model.
module tb_ldpc_dvb_dec_cnode_sort;
  localparam int NW = 8;
  localparam int IW = 5;
  localparam int CW = 16;

  typedef struct packed {
    logic [NW-1:0] min1;
    logic [NW-1:0] min2;
    logic [IW-1:0] col;
    logic          ps;
    logic [CW-1:0] ctx;
  } rv_t;
  typedef struct { rv_t v; int cyc; } ores_t;
  typedef struct { logic [IW:0] v; int cyc; } osgn_t;

  logic iclk = 1'b0;
  logic ireset = 1'b0;
  always #5 iclk = ~iclk;

  ldpc_dvb_dec_cnode_sort_if #(.pNODE_W(NW), .pIDX_W(IW), .pCTX_W(CW)) bus ();
  ldpc_dvb_dec_cnode_sort #(.pNODE_W(NW), .pIDX_W(IW), .pCTX_W(CW)) dut (
    .iclk(iclk), .ireset(ireset), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_cyc = 0;
  logic en_q = 1'b0;

  ores_t obs_res[$];
  osgn_t obs_sgn[$];
  rv_t   exp_res[$];
  logic [IW:0] exp_sgn[$];
  ores_t o_tmp;
  osgn_t s_tmp;

  // reference model state: candidate magnitudes in arrival order
  bit             m_open = 0;
  int             m_abs[$];
  int             m_idx[$];
  logic           m_ps;
  logic [CW-1:0]  m_ctx;

  always @(posedge iclk) begin
    cyc  <= cyc + 1;
    en_q <= bus.iclkena;
  end

  always @(negedge iclk) begin
    if (en_q === 1'b1) begin
      if (bus.ovn_min_val === 1'b1) begin
        o_tmp.v   = {bus.omin1, bus.omin2, bus.omin1_col, bus.oprod_sign, bus.octx};
        o_tmp.cyc = cyc;
        obs_res.push_back(o_tmp);
      end
      if (bus.osign_val === 1'b1) begin
        s_tmp.v   = {bus.osign, bus.osign_idx};
        s_tmp.cyc = cyc;
        obs_sgn.push_back(s_tmp);
      end
    end
  end

  task automatic model_edge(input bit sop, input bit eop, input bit mask,
                            input logic signed [NW-1:0] v, input logic [IW-1:0] idx,
                            input logic [CW-1:0] ctx);
    int iv;
    int a;
    iv = int'(v);
    a  = (iv < 0) ? -iv : iv;
    if (a > 127) a = 127;
    exp_sgn.push_back({(mask ? 1'b0 : v[NW-1]), idx});
    if (sop) begin
      m_open = 1;
      m_ctx  = ctx;
      m_abs.delete();
      m_idx.delete();
      if (mask) begin
        m_abs.push_back(127); m_idx.push_back(0);
        m_abs.push_back(127); m_idx.push_back(0);
        m_ps = 1'b0;
      end else begin
        m_abs.push_back(a);   m_idx.push_back(int'(idx));
        m_abs.push_back(127); m_idx.push_back(0);
        m_ps = v[NW-1];
      end
    end else if (m_open && !mask) begin
      m_abs.push_back(a);
      m_idx.push_back(int'(idx));
      m_ps = m_ps ^ v[NW-1];
    end
    if (eop && m_open) begin
      int k;
      int m2;
      rv_t rv;
      k  = 0;
      m2 = 127;
      for (int i = 1; i < m_abs.size(); i++) if (m_abs[i] < m_abs[k]) k = i;
      for (int i = 0; i < m_abs.size(); i++) if (i != k && m_abs[i] < m2) m2 = m_abs[i];
      rv.min1 = NW'(m_abs[k]);
      rv.min2 = NW'(m2);
      rv.col  = IW'(m_idx[k]);
      rv.ps   = m_ps;
      rv.ctx  = m_ctx;
      exp_res.push_back(rv);
      m_open = 0;
    end
  endtask

  task automatic set_idle();
    bus.iclkena = 1'b1; bus.istart = 1'b0; bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0;
    bus.ivnode = '0; bus.ivnode_idx = '0; bus.ivnode_mask = 1'b0; bus.icnode_ctx = '0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) begin @(posedge iclk); #1; end
  endtask

  task automatic drive_edge(input bit sop, input bit eop, input bit mask,
                            input logic signed [NW-1:0] v, input logic [IW-1:0] idx,
                            input logic [CW-1:0] ctx);
    bus.iclkena = 1'b1; bus.istart = 1'b0; bus.ival = 1'b1;
    bus.isop = sop; bus.ieop = eop; bus.ivnode_mask = mask;
    bus.ivnode = v; bus.ivnode_idx = idx; bus.icnode_ctx = ctx;
    model_edge(sop, eop, mask, v, idx, ctx);
    last_cyc = cyc;
    @(posedge iclk); #1;
  endtask

  task automatic stall_cycle();
    bus.iclkena = 1'b0;
    bus.ival = 1'($urandom_range(0, 1)); bus.isop = 1'($urandom_range(0, 1));
    bus.ieop = 1'($urandom_range(0, 1)); bus.ivnode = NW'($urandom);
    @(posedge iclk); #1;
  endtask

  function automatic logic signed [NW-1:0] rand_v();
    int r;
    int k;
    r = int'($urandom_range(0, 9));
    k = int'($urandom_range(0, 6)) - 3;
    if (r < 5)       rand_v = NW'($urandom);
    else if (r < 8)  rand_v = k[NW-1:0];
    else if (r == 8) rand_v = -8'sd128;
    else             rand_v = 8'sd127;
  endfunction

  task automatic clear_all();
    obs_res.delete(); obs_sgn.delete(); exp_res.delete(); exp_sgn.delete(); m_open = 0;
  endtask

  task automatic test_reset();
    set_idle();
    bus.iclkena = 1'b0;
    ireset = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    tests++;
    if ({bus.osign_val, bus.ovn_min_val} !== 2'b00) begin
      fails++; $display("FAIL reset_valids got %b want 00", {bus.osign_val, bus.ovn_min_val});
    end
    tests++;
    if ({bus.osign, bus.osign_idx, bus.omin1, bus.omin2, bus.omin1_col, bus.oprod_sign, bus.octx} !== '0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h/%h/%h/%h/%h want all zero", bus.osign, bus.osign_idx,
                        bus.omin1, bus.omin2, bus.omin1_col, bus.oprod_sign, bus.octx);
    end
    ireset = 1'b1;
    idle(2);
  endtask

  task automatic test_basic_rows();
    int t0;
    int te;
    clear_all();
    drive_edge(1, 0, 0, 8'sd5, 5'd0, 16'h00A5);
    t0 = last_cyc;
    drive_edge(0, 0, 0, -8'sd3, 5'd1, 16'h0);
    drive_edge(0, 0, 0, 8'sd7, 5'd2, 16'h0);
    drive_edge(0, 1, 0, -8'sd3, 5'd3, 16'h0);
    te = last_cyc;
    idle(4);
    tests++;
    if (obs_res.size() != 1) begin
      fails++; $display("FAIL row1_count got %0d want 1", obs_res.size());
    end else begin
      tests++;
      if (obs_res[0].v !== rv_t'{8'd3, 8'd3, 5'd1, 1'b0, 16'h00A5}) begin
        fails++; $display("FAIL row1_result got %h want %h", obs_res[0].v, rv_t'{8'd3, 8'd3, 5'd1, 1'b0, 16'h00A5});
      end
      tests++;
      if (obs_res[0].cyc != te + 2) begin
        fails++; $display("FAIL row1_latency got cycle %0d want %0d", obs_res[0].cyc, te + 2);
      end
    end
    tests++;
    if (obs_sgn.size() < 1 || obs_sgn[0].cyc != t0 + 1) begin
      fails++; $display("FAIL osign_latency got %0d entries first cycle %0d want cycle %0d", obs_sgn.size(),
                        (obs_sgn.size() > 0) ? obs_sgn[0].cyc : -1, t0 + 1);
    end

    clear_all();
    drive_edge(1, 1, 0, -8'sd128, 5'd4, 16'h1234);
    idle(4);
    tests++;
    if (obs_res.size() != 1 || obs_res[0].v !== rv_t'{8'd127, 8'd127, 5'd4, 1'b1, 16'h1234}) begin
      fails++; $display("FAIL single_edge got %0d results first %h want %h", obs_res.size(),
                        (obs_res.size() > 0) ? obs_res[0].v : '0, rv_t'{8'd127, 8'd127, 5'd4, 1'b1, 16'h1234});
    end

    clear_all();
    drive_edge(1, 0, 1, -8'sd2, 5'd0, 16'h0777);
    drive_edge(0, 0, 0, 8'sd9, 5'd1, 16'h0);
    drive_edge(0, 1, 0, -8'sd6, 5'd2, 16'h0);
    idle(4);
    tests++;
    if (obs_res.size() != 1 || obs_res[0].v !== rv_t'{8'd6, 8'd9, 5'd2, 1'b1, 16'h0777}) begin
      fails++; $display("FAIL masked_row got %0d results first %h want %h", obs_res.size(),
                        (obs_res.size() > 0) ? obs_res[0].v : '0, rv_t'{8'd6, 8'd9, 5'd2, 1'b1, 16'h0777});
    end
    tests++;
    if (obs_sgn.size() != 3 || {obs_sgn[0].v, obs_sgn[1].v, obs_sgn[2].v} !== {6'b0_00000, 6'b0_00001, 6'b1_00010}) begin
      fails++; $display("FAIL masked_row_signs got %0d entries want signs 0,0,1 at idx 0,1,2", obs_sgn.size());
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    clear_all();
    drive_edge(1, 0, 0, 8'sd4, 5'd0, 16'h0001);
    drive_edge(0, 0, 0, 8'sd1, 5'd1, 16'h0);
    drive_edge(0, 1, 0, 8'sd8, 5'd2, 16'h0);
    t1 = last_cyc;
    drive_edge(1, 0, 0, -8'sd7, 5'd0, 16'h0002);
    drive_edge(0, 1, 0, -8'sd7, 5'd1, 16'h0);
    t2 = last_cyc;
    idle(4);
    tests++;
    if (obs_res.size() != 2) begin
      fails++; $display("FAIL b2b_count got %0d want 2", obs_res.size());
    end else begin
      tests++;
      if (obs_res[0].v !== rv_t'{8'd1, 8'd4, 5'd1, 1'b0, 16'h0001} || obs_res[0].cyc != t1 + 2) begin
        fails++; $display("FAIL b2b_row1 got %h at %0d want %h at %0d", obs_res[0].v, obs_res[0].cyc,
                          rv_t'{8'd1, 8'd4, 5'd1, 1'b0, 16'h0001}, t1 + 2);
      end
      tests++;
      if (obs_res[1].v !== rv_t'{8'd7, 8'd7, 5'd0, 1'b0, 16'h0002} || obs_res[1].cyc != t2 + 2) begin
        fails++; $display("FAIL b2b_row2 got %h at %0d want %h at %0d", obs_res[1].v, obs_res[1].cyc,
                          rv_t'{8'd7, 8'd7, 5'd0, 1'b0, 16'h0002}, t2 + 2);
      end
    end
  endtask

  task automatic test_istart_flush();
    clear_all();
    drive_edge(1, 0, 0, 8'sd5, 5'd0, 16'h0AAA);
    drive_edge(0, 0, 0, 8'sd2, 5'd1, 16'h0);
    set_idle();
    bus.istart = 1'b1;
    @(posedge iclk); #1;
    m_open = 0;
    drive_edge(0, 1, 0, 8'sd1, 5'd2, 16'h0);
    idle(3);
    tests++;
    if (obs_res.size() != 0) begin
      fails++; $display("FAIL istart_no_result got %0d results want 0", obs_res.size());
    end
    drive_edge(1, 0, 0, 8'sd3, 5'd0, 16'h0BBB);
    drive_edge(0, 1, 0, -8'sd1, 5'd1, 16'h0);
    idle(4);
    tests++;
    if (obs_res.size() != 1 || obs_res[0].v !== rv_t'{8'd1, 8'd3, 5'd1, 1'b1, 16'h0BBB}) begin
      fails++; $display("FAIL istart_next_row got %0d results first %h want %h", obs_res.size(),
                        (obs_res.size() > 0) ? obs_res[0].v : '0, rv_t'{8'd1, 8'd3, 5'd1, 1'b1, 16'h0BBB});
    end
  endtask

  task automatic test_reset_midrow();
    clear_all();
    drive_edge(1, 0, 0, 8'sd10, 5'd0, 16'hBEEF);
    drive_edge(0, 1, 0, -8'sd20, 5'd1, 16'h0);
    idle(4);
    tests++;
    if (obs_res.size() != 1 || obs_res[0].v !== rv_t'{8'd10, 8'd20, 5'd0, 1'b1, 16'hBEEF}) begin
      fails++; $display("FAIL pre_reset_row got %0d results first %h want %h", obs_res.size(),
                        (obs_res.size() > 0) ? obs_res[0].v : '0, rv_t'{8'd10, 8'd20, 5'd0, 1'b1, 16'hBEEF});
    end
    clear_all();
    drive_edge(1, 0, 0, 8'sd6, 5'd0, 16'h0042);
    drive_edge(0, 0, 0, -8'sd3, 5'd1, 16'h0);
    set_idle();
    bus.iclkena = 1'b0;
    ireset = 1'b0;
    @(posedge iclk); #1;
    tests++;
    if ({bus.osign_val, bus.ovn_min_val, bus.osign, bus.osign_idx, bus.omin1, bus.omin2,
         bus.omin1_col, bus.oprod_sign, bus.octx} !== '0) begin
      fails++; $display("FAIL midrow_reset_outputs got val=%b/%b sign=%b idx=%h min=%h/%h col=%h ps=%b ctx=%h want all zero",
                        bus.osign_val, bus.ovn_min_val, bus.osign, bus.osign_idx, bus.omin1, bus.omin2,
                        bus.omin1_col, bus.oprod_sign, bus.octx);
    end
    ireset = 1'b1;
    m_open = 0;
    obs_sgn.delete();
    drive_edge(0, 1, 0, 8'sd1, 5'd2, 16'h0);
    idle(4);
    tests++;
    if (obs_res.size() != 0) begin
      fails++; $display("FAIL midrow_reset_stale got %0d results want 0", obs_res.size());
    end
    tests++;
    if (obs_sgn.size() != 1 || obs_sgn[0].v !== 6'b0_00010) begin
      fails++; $display("FAIL orphan_sign got %0d entries want 1 with idx 2", obs_sgn.size());
    end
  endtask

  task automatic test_random();
    clear_all();
    for (int r = 0; r < 80; r++) begin
      int len;
      logic [CW-1:0] ctx;
      len = int'($urandom_range(1, 6));
      ctx = CW'($urandom);
      if ($urandom_range(0, 7) == 0)
        drive_edge(0, 1, 1'($urandom_range(0, 1)), rand_v(), IW'($urandom), '0);
      if ($urandom_range(0, 7) == 0) begin
        drive_edge(1, 0, 0, rand_v(), IW'($urandom), ~ctx);
        drive_edge(0, 0, 0, rand_v(), IW'($urandom), '0);
      end
      for (int e = 0; e < len; e++) begin
        if ($urandom_range(0, 7) == 0) stall_cycle();
        drive_edge(e == 0, e == len - 1, $urandom_range(0, 3) == 0, rand_v(), IW'($urandom), ctx);
      end
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(5);
    tests++;
    if (obs_res.size() != exp_res.size()) begin
      fails++; $display("FAIL rand_result_count got %0d want %0d", obs_res.size(), exp_res.size());
    end
    for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++) begin
      tests++;
      if (obs_res[i].v !== exp_res[i]) begin
        fails++; $display("FAIL rand_result[%0d] got %h want %h", i, obs_res[i].v, exp_res[i]);
      end
    end
    tests++;
    if (obs_sgn.size() != exp_sgn.size()) begin
      fails++; $display("FAIL rand_sign_count got %0d want %0d", obs_sgn.size(), exp_sgn.size());
    end
    for (int i = 0; i < exp_sgn.size() && i < obs_sgn.size(); i++) begin
      tests++;
      if (obs_sgn[i].v !== exp_sgn[i]) begin
        fails++; $display("FAIL rand_sign[%0d] got %h want %h", i, obs_sgn[i].v, exp_sgn[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rows();
    test_back_to_back();
    test_istart_flush();
    test_reset_midrow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
